// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_lock;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  logic        err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-indexed data memory between the CPU and DMA ports,
// with optional locked bursts capped at MAX_BURST back-to-back accesses.
module dmem_arbiter #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned     BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]   BurstLast = BW'(MAX_BURST - 1);
  localparam logic [31:0]     DepthW    = 32'(DEPTH);

  typedef enum logic [1:0] {StIdle, StCpu, StDma} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;  // 0 = CPU granted last, 1 = DMA
  logic [BW-1:0]   burst_q, burst_d;

  logic            g_req, g_we, g_lock;
  logic [31:0]     g_addr, g_wdata;
  logic            in_range;
  logic            access;

  // Select the granted requester's inputs; the other side is ignored.
  always_comb begin
    g_req   = 1'b0;
    g_we    = 1'b0;
    g_lock  = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    case (state_q)
      StCpu: begin
        g_req   = bus.cpu_req;
        g_we    = bus.cpu_we;
        g_lock  = bus.cpu_lock;
        g_addr  = bus.cpu_addr;
        g_wdata = bus.cpu_wdata;
      end
      StDma: begin
        g_req   = bus.dma_req;
        g_we    = bus.dma_we;
        g_lock  = bus.dma_lock;
        g_addr  = bus.dma_addr;
        g_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign in_range = g_addr < DepthW;
  assign access   = g_req && !reset;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    burst_d       = burst_q;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.dma_ack   = 1'b0;
    bus.dma_rdata = '0;
    bus.err       = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req && (!bus.dma_req || last_q)) begin
          state_d = StCpu;
          burst_d = '0;
        end else if (bus.dma_req) begin
          state_d = StDma;
          burst_d = '0;
        end
      end
      StCpu, StDma: begin
        if (g_req) begin
          last_d = (state_q == StDma);
          if (g_lock && (burst_q < BurstLast)) begin
            burst_d = burst_q + 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Out-of-range accesses still ack but never write and return zero data.
    if (access) begin
      bus.mem_addr  = g_addr;
      bus.mem_wdata = g_wdata;
      bus.mem_we    = g_we && in_range;
      bus.err       = !in_range;
      if (state_q == StCpu) begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = in_range ? bus.mem_rdata : '0;
      end else begin
        bus.dma_ack   = 1'b1;
        bus.dma_rdata = in_range ? bus.mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a transaction-level model of ownership, burst length and memory contents.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;
  logic init_mem = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory with combinational read; junk outside the array so the arbiter must zero it.
  logic [31:0] mem [DEPTH];
  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[5:0]] : 32'h0BAD_0BAD;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i <= 10) ? 32'(10 - i) : 32'h0;
    end else if (bus.mem_we && bus.mem_addr < 32'(DEPTH)) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner 0 = nobody, 1 = CPU, 2 = DMA; held = accesses done in current hold.
  int          m_owner, m_held, m_last;
  int          x_owner, x_held, x_last;
  logic        x_wr;
  logic [31:0] x_waddr, x_wdata;
  logic [31:0] ref_mem [DEPTH];

  logic        o_cack, o_dack, o_err, o_we;
  logic [31:0] o_addr, o_crd, o_drd;

  task automatic step();
    logic        e_cack, e_dack, e_err, e_we, acc, r, w, l, inr;
    logic [31:0] e_crd, e_drd, a, d, rd;
    @(negedge clk);
    o_cack = bus.cpu_ack;  o_dack = bus.dma_ack;  o_err = bus.err;
    o_we   = bus.mem_we;   o_addr = bus.mem_addr; o_crd = bus.cpu_rdata; o_drd = bus.dma_rdata;
    e_cack = 0; e_dack = 0; e_err = 0; e_we = 0; acc = 0; e_crd = 0; e_drd = 0;
    x_owner = m_owner; x_held = m_held; x_last = m_last; x_wr = 0; x_waddr = 0; x_wdata = 0;
    if (m_owner == 0) begin
      if (bus.cpu_req && (!bus.dma_req || m_last == 2)) begin
        x_owner = 1; x_held = 0;
      end else if (bus.dma_req) begin
        x_owner = 2; x_held = 0;
      end
    end else begin
      r = (m_owner == 1) ? bus.cpu_req   : bus.dma_req;
      w = (m_owner == 1) ? bus.cpu_we    : bus.dma_we;
      l = (m_owner == 1) ? bus.cpu_lock  : bus.dma_lock;
      a = (m_owner == 1) ? bus.cpu_addr  : bus.dma_addr;
      d = (m_owner == 1) ? bus.cpu_wdata : bus.dma_wdata;
      if (r) begin
        acc = 1;
        inr = a < 32'(DEPTH);
        rd  = inr ? ref_mem[a[5:0]] : 32'h0;
        if (m_owner == 1) begin e_cack = 1; e_crd = rd; end
        else              begin e_dack = 1; e_drd = rd; end
        e_err  = !inr;
        e_we   = w && inr;
        x_last = m_owner;
        x_held = m_held + 1;
        if (!(l && x_held < MAX_BURST)) x_owner = 0;
        x_wr = e_we; x_waddr = a; x_wdata = d;
      end else begin
        x_owner = 0;
      end
    end
    check_eq("cpu_ack",   32'(o_cack), 32'(e_cack));
    check_eq("dma_ack",   32'(o_dack), 32'(e_dack));
    check_eq("err",       32'(o_err),  32'(e_err));
    check_eq("mem_we",    32'(o_we),   32'(e_we));
    check_eq("cpu_rdata", o_crd, e_crd);
    check_eq("dma_rdata", o_drd, e_drd);
    if (acc) begin
      check_eq("mem_addr",  o_addr, x_waddr);
      check_eq("mem_wdata", bus.mem_wdata, x_wdata);
    end else if (m_owner == 0) begin
      check_eq("idle_addr", o_addr, 32'h0);
    end
    @(posedge clk);
    if (x_wr) ref_mem[x_waddr[5:0]] = x_wdata;
    m_owner = x_owner; m_held = x_held; m_last = x_last;
    #1;
  endtask

  task automatic drive(int s, logic req, logic we, logic [31:0] addr, logic [31:0] wd,
                       logic lock);
    if (s == 0) begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
      bus.cpu_wdata = wd; bus.cpu_lock = lock;
    end else begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr;
      bus.dma_wdata = wd; bus.dma_lock = lock;
    end
  endtask

  task automatic do_reset(bit init);
    reset = 1'b1;
    init_mem = init;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check_eq("rst_outputs", 32'({bus.cpu_ack, bus.dma_ack, bus.err, bus.mem_we}), 32'h0);
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    if (init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i <= 10) ? 32'(10 - i) : 32'h0;
    reset = 1'b0;
    m_owner = 0; m_held = 0; m_last = 2;
  endtask

  task automatic wait_ack(int s, int budget);
    logic got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = (s == 0) ? o_cack : o_dack;
    end
    check_eq("ack_within_budget", 32'(got), 32'd1);
  endtask

  task automatic rand_side(int s);
    logic [31:0] a;
    a = ($urandom % 8 == 0) ? 32'(64 + $urandom % 8) : 32'($urandom % 16);
    drive(s, ($urandom % 4) != 0, 1'($urandom), a, $urandom, ($urandom % 3) == 0);
  endtask

  initial begin
    logic [31:0] tr;
    int          k;

    do_reset(1);

    // Single unlocked CPU read: one IDLE cycle, then the ack.
    drive(0, 1, 0, 3, 0, 0);
    step();
    check_eq("t1_lat_ack", 32'(o_cack), 32'd0);
    step();
    check_eq("t1_ack", 32'(o_cack), 32'd1);
    check_eq("t1_rdata", o_crd, 32'd7);
    check_eq("t1_we", 32'(o_we), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check_eq("t1_after", 32'(o_cack), 32'd0);

    // DMA write, then CPU read-back.
    drive(1, 1, 1, 5, 32'hDEAD_BEEF, 0);
    wait_ack(1, 4);
    check_eq("t3_we", 32'(o_we), 32'd1);
    check_eq("t3_addr", o_addr, 32'd5);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 5, 0, 0);
    wait_ack(0, 4);
    check_eq("t3_rdata", o_crd, 32'hDEAD_BEEF);

    // Out-of-range write: acked with err, no write.
    drive(0, 1, 1, 64, 32'h1234_5678, 0);
    wait_ack(0, 4);
    check_eq("t5_err", 32'(o_err), 32'd1);
    check_eq("t5_we", 32'(o_we), 32'd0);
    check_eq("t5_rdata", o_crd, 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    wait_ack(0, 4);
    check_eq("t5_mem0", o_crd, 32'd10);
    drive(0, 0, 0, 0, 0, 0);

    // Simultaneous unlocked requests alternate, CPU first after reset.
    do_reset(0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    tr = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      tr = {tr[29:0], o_cack, o_dack};
      if (o_cack) check_eq("t2_crd", o_crd, 32'd10);
      if (o_dack) check_eq("t2_drd", o_drd, 32'd9);
    end
    check_eq("t2_trace", tr, 32'b00_10_00_01_00_10_00_01);

    // Locked CPU burst capped at MAX_BURST while DMA waits.
    do_reset(0);
    drive(0, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 1, 0, 0);
    tr = 0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      tr = {tr[29:0], o_cack, o_dack};
      if (o_cack) begin
        k++;
        if (k <= 4) check_eq("t4_rdata", o_crd, 32'(11 - k));
        bus.cpu_addr = 32'(k);
        if (k == 5) bus.cpu_req = 1'b0;
      end
      if (o_dack) bus.dma_req = 1'b0;
    end
    check_eq("t4_trace", tr, 32'b00_10_10_10_10_00_01_00_10);
    check_eq("t4_cpu_count", 32'(k), 32'd5);

    // Reset in the 2nd locked DMA write cycle.
    do_reset(0);
    drive(1, 1, 1, 20, 32'hAAAA_0001, 1);
    step();
    step();
    check_eq("t6_first_ack", 32'(o_dack), 32'd1);
    drive(1, 1, 1, 21, 32'hBBBB_0002, 1);
    #3;
    check_eq("t6_pre_ack", 32'(bus.dma_ack), 32'd1);
    check_eq("t6_pre_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_ack", 32'(bus.dma_ack), 32'd0);
    check_eq("t6_rst_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    m_owner = 0; m_held = 0; m_last = 2;
    drive(0, 1, 0, 21, 0, 0);
    step();
    check_eq("t6_lat0", 32'(o_cack), 32'd0);
    step();
    check_eq("t6_lat1", 32'(o_cack), 32'd1);
    check_eq("t6_nowrite", o_crd, 32'd0);
    drive(0, 1, 0, 20, 0, 0);
    wait_ack(0, 4);
    check_eq("t6_first_write", o_crd, 32'hAAAA_0001);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Random traffic; a requester holds its request until acked.
    for (int c = 0; c < 800; c++) begin
      if (o_cack || !bus.cpu_req) rand_side(0);
      if (o_dack || !bus.dma_req) rand_side(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-indexed data memory between two requesters: the CPU load/store port and a DMA/debug port.
- Round-robin arbitration with an optional locked burst.
- Drives the memory's write-enable, address and write-data inputs; returns its combinational read data to the granted requester.
- Sits between the datapath/DMA engine and the data memory.

Parameters:
- DEPTH, 64: number of 32-bit words in the memory; a word address >= DEPTH is out of range.
- MAX_BURST, 4: maximum consecutive accesses one requester may hold under lock (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  32  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_lock  in  1  CPU requests to keep the grant after this access
- cpu_ack  out  1  CPU access performed this cycle
- cpu_rdata  out  32  CPU read data; valid when cpu_ack=1
- dma_req, dma_we, dma_addr, dma_wdata, dma_lock  in  1/1/32/32/1  same as the cpu_* inputs, DMA side
- dma_ack  out  1  DMA access performed this cycle
- dma_rdata  out  32  DMA read data; valid when dma_ack=1
- err  out  1  the acknowledged access this cycle was out of range
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- States: IDLE, CPU, DMA. Registers: state, last (last granted: 0=CPU, 1=DMA), burst_cnt (width clog2(MAX_BURST)+1).
- Reset (async, immediate): state=IDLE, last=DMA (so CPU wins the first tie), burst_cnt=0.
- All outputs are combinational from state and the granted requester's inputs. In IDLE and under reset, every output is 0.
- IDLE transitions:
  - Only one request -> that requester's state.
  - Both requests -> requester != last.
  - No request -> stay in IDLE.
  - burst_cnt <= 0 on entry to CPU/DMA.
  - IDLE never acks; minimum latency is req-rise -> ack on the next cycle.
- CPU state with cpu_req=1 (access cycle):
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - mem_we=cpu_we when in range (cpu_addr < DEPTH), else 0.
  - cpu_ack=1. cpu_rdata=mem_rdata when in range, else 0.
  - err=1 when out of range.
  - last <= CPU.
- DMA state: symmetric to CPU, with DMA inputs.
- Leaving an access cycle:
  - If lock=1 and burst_cnt < MAX_BURST-1: stay, burst_cnt++. This gives back-to-back accesses, one per cycle.
  - Else -> IDLE. The unlocked rate is therefore 1 access per 2 cycles per requester.
- In CPU/DMA with that requester's req=0: no access, no ack, mem_we=0; next state IDLE (lock abandoned).
- Burst cap: after MAX_BURST consecutive acks the state returns to IDLE. The other requester wins if requesting (last points at the holder).
- The non-granted requester's ack and rdata stay 0; its inputs are ignored.
- A write commits at the clock edge ending its ack cycle. A read in that same cycle returns the old memory content.
- Out-of-range accesses complete normally (ack, count toward the burst) with no write.
- Reset mid-burst: all outputs go to 0 immediately; no further write is issued; any partial burst is discarded.
- Address is used as a word index; no byte-lane handling; upper address bits participate only in the range check.

Test Plan:
- Memory preloaded mem[i]=10-i for i=0..10. CPU read addr 3, lock=0 -> cycle 1 IDLE; cycle 2 cpu_ack=1, cpu_rdata=7, mem_we=0, err=0; cycle 3 state IDLE, ack=0.
- cpu_req and dma_req rise together, reads of addr 0 / addr 1, both unlocked and held -> acks in the order CPU (rdata 10), DMA (rdata 9), CPU, DMA, each separated by one IDLE cycle.
- DMA writes 32'hDEAD_BEEF to addr 5, then CPU reads addr 5 -> during the DMA ack cycle mem_we=1, mem_addr=5; CPU subsequently reads 32'hDEAD_BEEF.
- MAX_BURST=4: CPU lock=1 with reads of addr 0,1,2,3,4 while dma_req is held -> cpu_ack high for 4 consecutive cycles (rdata 10,9,8,7), then IDLE, then dma_ack, and only then the 5th CPU access.
- CPU write to addr 64 with DEPTH=64 -> cpu_ack=1, err=1, mem_we=0, cpu_rdata=0; memory unchanged.
- Reset asserted mid-burst, in the 2nd locked DMA write cycle -> mem_we and dma_ack fall to 0 in the same cycle; after release, a CPU-only request is granted with latency 1.
